shadowmask_loader: RTL and testbench

- Sequencer that programs the CRT shadow-mask overlay through its 16-bit command port (cmd_wr/cmd_in) in the clk_sys domain.
- On a start request it emits, in order:
  - the header command (mode bits; also resets the target's LUT write index),
  - the vmax command,
  - the hmax command,
  - the LUT entries, read from an external pattern RAM with 1-cycle read latency.
- It replaces ad-hoc HPS command streaming with a deterministic, restartable load.

---
 rtl/shadowmask_loader.sv | 215 +++++++++++++++++++++
 tb/tb_shadowmask_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shadowmask_loader.sv
// Shadow-mask overlay loader: on start, writes header, vmax, hmax and then the
// LUT entries streamed from a 1-cycle-latency pattern RAM to the 16-bit command port.
module shadowmask_loader #(
    parameter int unsigned CMD_GAP = 0
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hdr_only,
    input  logic        cfg_enable,
    input  logic        cfg_rotate,
    input  logic        cfg_2x,
    input  logic [3:0]  cfg_vsize,
    input  logic [3:0]  cfg_hsize,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic [10:0] mem_rdata,
    output logic        cmd_wr,
    output logic [15:0] cmd_in,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_VMAX,
        S_HMAX,
        S_LUT,
        S_GAP,
        S_FIN
    } state_e;

    localparam logic [3:0] GAP_LEN = 4'(CMD_GAP);
    localparam bit         HAS_GAP = (CMD_GAP != 0);

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    logic [3:0]  gap_q, gap_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        ho_q, ho_d;
    logic        en_q, en_d;
    logic        rot_q, rot_d;
    logic        x2_q, x2_d;
    logic [3:0]  vs_q, vs_d;
    logic [3:0]  hs_q, hs_d;
    logic        cmd_wr_q, cmd_wr_d;
    logic [15:0] cmd_q, cmd_d;
    logic        mem_rd_q, mem_rd_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // cnt_q counts LUT writes issued so far, so outside a LUT write cycle it is
    // also the index of the next entry to fetch.
    logic [8:0]  n_entries;
    logic [8:0]  cnt_inc;
    state_e      nxt_wr;
    logic        in_wr_state;
    logic        issue;

    assign n_entries   = {1'b0, vs_q, hs_q} + 9'd1;
    assign cnt_inc     = cnt_q + 9'd1;
    assign in_wr_state = (state_q == S_HDR) || (state_q == S_VMAX) ||
                         (state_q == S_HMAX) || (state_q == S_LUT);

    always_comb begin
        nxt_wr = S_IDLE;
        case (state_q)
            S_HDR:   nxt_wr = ho_q ? S_FIN : S_VMAX;
            S_VMAX:  nxt_wr = S_HMAX;
            S_HMAX:  nxt_wr = S_LUT;
            S_LUT:   nxt_wr = (cnt_q == n_entries) ? S_FIN : S_LUT;
            S_GAP:   nxt_wr = ret_q;
            default: nxt_wr = S_IDLE;
        endcase
    end

    assign issue = !start &&
                   (((state_q == S_GAP) && (gap_q == 4'd1)) ||
                    (in_wr_state && (nxt_wr != S_FIN) && !HAS_GAP));

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        ho_d       = ho_q;
        en_d       = en_q;
        rot_d      = rot_q;
        x2_d       = x2_q;
        vs_d       = vs_q;
        hs_d       = hs_q;
        cmd_wr_d   = 1'b0;
        cmd_d      = 16'h0000;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (start) begin
            // Restart from any state: the header resets the target's LUT index.
            ho_d     = hdr_only;
            en_d     = cfg_enable;
            rot_d    = cfg_rotate;
            x2_d     = cfg_2x;
            vs_d     = cfg_vsize;
            hs_d     = cfg_hsize;
            cnt_d    = 9'd0;
            gap_d    = 4'd0;
            state_d  = S_HDR;
            cmd_wr_d = 1'b1;
            cmd_d    = {12'h000, cfg_enable, cfg_rotate, cfg_2x, 1'b0};
            busy_d   = 1'b1;
        end else if (issue) begin
            state_d  = nxt_wr;
            cmd_wr_d = 1'b1;
            case (nxt_wr)
                S_VMAX:  cmd_d = {3'b001, 9'h000, vs_q};
                S_HMAX:  cmd_d = {3'b010, 9'h000, hs_q};
                S_LUT:   cnt_d = cnt_inc;
                default: cmd_d = 16'h0000;
            endcase
            // Back-to-back: the write cycle itself doubles as the next prefetch.
            if (!HAS_GAP) begin
                if (nxt_wr == S_HMAX) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = cnt_q[7:0];
                end else if ((nxt_wr == S_LUT) && (cnt_inc != n_entries)) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = cnt_inc[7:0];
                end
            end
        end else begin
            case (state_q)
                S_HDR, S_VMAX, S_HMAX, S_LUT: begin
                    if (nxt_wr == S_FIN) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_LEN;
                        ret_d   = nxt_wr;
                        if ((GAP_LEN == 4'd1) && (nxt_wr == S_LUT)) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = cnt_q[7:0];
                        end
                    end
                end
                S_GAP: begin
                    gap_d = gap_q - 4'd1;
                    if ((gap_q == 4'd2) && (ret_q == S_LUT)) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = cnt_q[7:0];
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            gap_q      <= 4'd0;
            cnt_q      <= 9'd0;
            ho_q       <= 1'b0;
            en_q       <= 1'b0;
            rot_q      <= 1'b0;
            x2_q       <= 1'b0;
            vs_q       <= 4'd0;
            hs_q       <= 4'd0;
            cmd_wr_q   <= 1'b0;
            cmd_q      <= 16'h0000;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            ho_q       <= ho_d;
            en_q       <= en_d;
            rot_q      <= rot_d;
            x2_q       <= x2_d;
            vs_q       <= vs_d;
            hs_q       <= hs_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_q      <= cmd_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // RAM data only arrives in the LUT write cycle, so it bypasses cmd_q.
    assign cmd_in   = (state_q == S_LUT) ? {5'b01100, mem_rdata} : cmd_q;
    assign cmd_wr   = cmd_wr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    a_done_not_wr: assert property (@(posedge clk_sys) disable iff (!rst_n)
        !(done_q && cmd_wr_q));
    a_rd_then_lut: assert property (@(posedge clk_sys) disable iff (!rst_n)
        (mem_rd_q && !start) |=> (cmd_wr_q && (state_q == S_LUT)));

endmodule

// File: tb/tb_shadowmask_loader.sv
// Bench for shadowmask_loader: two instances (CMD_GAP=0 and 2) share stimulus;
// a per-cycle expected-record queue per instance is filled on each start.
module tb_shadowmask_loader;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        start, hdr_only, cfg_enable, cfg_rotate, cfg_2x;
  logic [3:0]  cfg_vsize, cfg_hsize;

  logic [7:0]  mem_addr_g0, mem_addr_g2;
  logic        mem_rd_g0, mem_rd_g2;
  logic [10:0] rdata_g0, rdata_g2;
  logic        cmd_wr_g0, cmd_wr_g2;
  logic [15:0] cmd_in_g0, cmd_in_g2;
  logic        busy_g0, busy_g2, done_g0, done_g2;

  logic [10:0] mem [256];

  // record: {wr, cmd[15:0], rd, addr[7:0], done, busy}
  logic [27:0] exp_g0_q[$];
  logic [27:0] exp_g2_q[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt_g0 = 0, done_cnt_g2 = 0;
  int          rd_cnt_g0 = 0, rd_cnt_g2 = 0;
  logic [255:0] seen_g0;

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  shadowmask_loader #(.CMD_GAP(0)) u_g0 (
    .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .hdr_only(hdr_only),
    .cfg_enable(cfg_enable), .cfg_rotate(cfg_rotate), .cfg_2x(cfg_2x),
    .cfg_vsize(cfg_vsize), .cfg_hsize(cfg_hsize),
    .mem_addr(mem_addr_g0), .mem_rd(mem_rd_g0), .mem_rdata(rdata_g0),
    .cmd_wr(cmd_wr_g0), .cmd_in(cmd_in_g0), .busy(busy_g0), .done(done_g0)
  );

  shadowmask_loader #(.CMD_GAP(2)) u_g2 (
    .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .hdr_only(hdr_only),
    .cfg_enable(cfg_enable), .cfg_rotate(cfg_rotate), .cfg_2x(cfg_2x),
    .cfg_vsize(cfg_vsize), .cfg_hsize(cfg_hsize),
    .mem_addr(mem_addr_g2), .mem_rd(mem_rd_g2), .mem_rdata(rdata_g2),
    .cmd_wr(cmd_wr_g2), .cmd_in(cmd_in_g2), .busy(busy_g2), .done(done_g2)
  );

  // pattern RAMs, 1-cycle read latency
  always @(posedge clk_sys) begin
    if (mem_rd_g0) rdata_g0 <= mem[mem_addr_g0];
    if (mem_rd_g2) rdata_g2 <= mem[mem_addr_g2];
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  task automatic push_seq(input int g, input bit ho, input bit en, input bit rot, input bit x2,
                          input logic [3:0] vs, input logic [3:0] hs);
    logic [15:0] words[$];
    logic [27:0] r;
    int          n, len, j;
    words.push_back({12'h000, en, rot, x2, 1'b0});
    if (!ho) begin
      words.push_back({3'b001, 9'h000, vs});
      words.push_back({3'b010, 9'h000, hs});
      n = int'({vs, hs}) + 1;
      for (int k = 0; k < n; k++) words.push_back({5'b01100, mem[k]});
    end
    len = (words.size() - 1) * (g + 1) + 1;
    for (int off = 1; off <= len + 1; off++) begin
      r = '0;
      if (off <= len) r[0] = 1'b1;
      if (off == len + 1) r[1] = 1'b1;
      if (off <= len && ((off - 1) % (g + 1)) == 0) begin
        r[27] = 1'b1;
        r[26:11] = words[(off - 1) / (g + 1)];
      end
      if (off < len && (off % (g + 1)) == 0) begin
        j = off / (g + 1);
        if (j >= 3) begin
          r[10] = 1'b1;
          r[9:2] = 8'(j - 3);
        end
      end
      if (g == 0) exp_g0_q.push_back(r);
      else exp_g2_q.push_back(r);
    end
  endtask

  // ---------------- monitors (sampled on falling edge) ----------------
  always @(negedge clk_sys) begin
    logic [27:0] e;
    e = (exp_g0_q.size() > 0) ? exp_g0_q.pop_front() : 28'h0;
    check_eq("g0_wr", 32'(cmd_wr_g0), 32'(e[27]));
    check_eq("g0_cmd", 32'(cmd_in_g0), 32'(e[26:11]));
    check_eq("g0_rd", 32'(mem_rd_g0), 32'(e[10]));
    if (e[10]) check_eq("g0_addr", 32'(mem_addr_g0), 32'(e[9:2]));
    check_eq("g0_done", 32'(done_g0), 32'(e[1]));
    check_eq("g0_busy", 32'(busy_g0), 32'(e[0]));
    if (done_g0) done_cnt_g0++;
    if (mem_rd_g0) begin
      rd_cnt_g0++;
      seen_g0[mem_addr_g0] = 1'b1;
    end
  end

  always @(negedge clk_sys) begin
    logic [27:0] e;
    e = (exp_g2_q.size() > 0) ? exp_g2_q.pop_front() : 28'h0;
    check_eq("g2_wr", 32'(cmd_wr_g2), 32'(e[27]));
    check_eq("g2_cmd", 32'(cmd_in_g2), 32'(e[26:11]));
    check_eq("g2_rd", 32'(mem_rd_g2), 32'(e[10]));
    if (e[10]) check_eq("g2_addr", 32'(mem_addr_g2), 32'(e[9:2]));
    check_eq("g2_done", 32'(done_g2), 32'(e[1]));
    check_eq("g2_busy", 32'(busy_g2), 32'(e[0]));
    if (done_g2) done_cnt_g2++;
    if (mem_rd_g2) rd_cnt_g2++;
  end

  // ---------------- drivers (called just after a rising edge) ----------------
  task automatic do_start(input bit ho, input bit en, input bit rot, input bit x2,
                          input logic [3:0] vs, input logic [3:0] hs);
    start = 1'b1; hdr_only = ho; cfg_enable = en; cfg_rotate = rot; cfg_2x = x2;
    cfg_vsize = vs; cfg_hsize = hs;
    @(posedge clk_sys); #1;
    start = 1'b0;
    hdr_only = 1'($urandom_range(0, 1));
    cfg_enable = 1'($urandom_range(0, 1));
    cfg_rotate = 1'($urandom_range(0, 1));
    cfg_2x = 1'($urandom_range(0, 1));
    cfg_vsize = 4'($urandom_range(0, 15));
    cfg_hsize = 4'($urandom_range(0, 15));
    exp_g0_q.delete();
    exp_g2_q.delete();
    push_seq(0, ho, en, rot, x2, vs, hs);
    push_seq(2, ho, en, rot, x2, vs, hs);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (exp_g0_q.size() == 0 && exp_g2_q.size() == 0) break;
      @(posedge clk_sys); #1;
    end
    check_eq("idle_timeout", 32'(exp_g0_q.size() + exp_g2_q.size()), 32'd0);
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; hdr_only = 1'b0; cfg_enable = 1'b0; cfg_rotate = 1'b0;
    cfg_2x = 1'b0; cfg_vsize = 4'd0; cfg_hsize = 4'd0;
    rdata_g0 = 11'h0; rdata_g2 = 11'h0; seen_g0 = '0;
    for (int k = 0; k < 256; k++) mem[k] = 11'($urandom_range(0, 2047));
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // basic 36-entry load
    do_start(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3);
    wait_idle();

    // full 256-entry load
    rd_cnt_g0 = 0; rd_cnt_g2 = 0; seen_g0 = '0;
    do_start(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd15);
    wait_idle();
    check_eq("rd_count_256_g0", 32'(rd_cnt_g0), 32'd256);
    check_eq("rd_count_256_g2", 32'(rd_cnt_g2), 32'd256);
    check_eq("addr_cover_g0", 32'($countones(seen_g0)), 32'd256);

    // single entry
    do_start(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
    wait_idle();

    // header only
    rd_cnt_g0 = 0; rd_cnt_g2 = 0;
    do_start(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd9);
    wait_idle();
    check_eq("hdr_only_rd_g0", 32'(rd_cnt_g0), 32'd0);
    check_eq("hdr_only_rd_g2", 32'(rd_cnt_g2), 32'd0);

    // restart during LUT entry 10 of a 36-entry load
    done_cnt_g0 = 0; done_cnt_g2 = 0;
    do_start(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3);
    repeat (13) @(posedge clk_sys);
    #1;
    do_start(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd1);
    wait_idle();
    check_eq("abort_done_g0", 32'(done_cnt_g0), 32'd1);
    check_eq("abort_done_g2", 32'(done_cnt_g2), 32'd1);

    // restart in the FIN cycle
    done_cnt_g0 = 0; done_cnt_g2 = 0;
    do_start(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    @(posedge clk_sys); #1;
    do_start(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
    wait_idle();
    check_eq("fin_restart_done_g0", 32'(done_cnt_g0), 32'd2);
    check_eq("fin_restart_done_g2", 32'(done_cnt_g2), 32'd2);

    // reset during VMAX
    do_start(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3);
    @(posedge clk_sys); #1;
    rst_n = 1'b0;
    exp_g0_q.delete();
    exp_g2_q.delete();
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk_sys);
    #1;

    // random configurations
    for (int i = 0; i < 6; i++) begin
      do_start(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
